// File: rtl/lsu_mem_sequencer_if.sv
// lsu_mem_sequencer_if: bundles the issue, data-memory and writeback signal groups of the sequencer.
// Latency: none (wiring only).
// Backpressure: in_valid/in_ready on issue, mem_req held until mem_ack on memory, wb has no stall.
// Ports: master = the sequencer (drives in_ready, mem_*, wb_*, busy); slave = surrounding pipeline/memory.
interface lsu_mem_sequencer_if #(
  parameter int TAG_W = 5
);
  // control
  logic             flush;
  logic             busy;
  // issue side
  logic             in_valid;
  logic             in_ready;
  logic             in_is_load;
  logic             in_is_store;
  logic             in_is_byte;
  logic             in_is_word;
  logic [31:0]      in_addr;
  logic [31:0]      in_wdata;
  logic [TAG_W-1:0] in_tag;
  // data memory side
  logic             mem_req;
  logic             mem_we;
  logic [3:0]       mem_be;
  logic [31:0]      mem_addr;
  logic [31:0]      mem_wdata;
  logic             mem_ack;
  logic [31:0]      mem_rdata;
  // writeback side
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [31:0]      wb_data;
  logic             wb_err;

  modport master (
    input  flush,
    output busy,
    input  in_valid, in_is_load, in_is_store, in_is_byte, in_is_word, in_addr, in_wdata, in_tag,
    output in_ready,
    output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata,
    output wb_valid, wb_tag, wb_data, wb_err
  );

  modport slave (
    output flush,
    input  busy,
    output in_valid, in_is_load, in_is_store, in_is_byte, in_is_word, in_addr, in_wdata, in_tag,
    input  in_ready,
    input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_ack, mem_rdata,
    input  wb_valid, wb_tag, wb_data, wb_err
  );
endinterface

// File: rtl/lsu_mem_sequencer.sv
// lsu_mem_sequencer: in-order load/store sequencer between issue and a single-ported data memory.
// Latency: push -> mem_req next cycle; wb_valid the cycle after mem_ack (3 cycles minimum per op).
// Backpressure: in_ready drops while the DEPTH-entry queue is full; mem_req is held until mem_ack.
// Ports: clk, rst (sync, active-high); bus (master modport) with flush/busy, issue, memory and wb groups.
// TAG_W must match the TAG_W of the connected interface instance.
module lsu_mem_sequencer #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 5
) (
  input  logic                clk,
  input  logic                rst,
  lsu_mem_sequencer_if.master bus
);

  localparam int               PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int               CNT_W    = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic             is_load;
    logic             is_store;
    logic             is_byte;
    logic             is_word;
    logic [31:0]      addr;
    logic [31:0]      wdata;
    logic [TAG_W-1:0] tag;
  } op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WB
  } state_t;

  op_t              fifo_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  state_t           state;
  // Set when the op on the bus was flushed; its completion is then swallowed.
  logic             discard;
  logic [1:0]       lane_q;
  logic             byte_q;
  logic             load_q;

  op_t              in_op;
  op_t              head;
  logic             queue_empty;
  logic             head_legal;
  logic             push;
  logic             pop;
  logic [7:0]       rd_byte;
  logic [31:0]      load_result;

  assign in_op = '{
    is_load:  bus.in_is_load,
    is_store: bus.in_is_store,
    is_byte:  bus.in_is_byte,
    is_word:  bus.in_is_word,
    addr:     bus.in_addr,
    wdata:    bus.in_wdata,
    tag:      bus.in_tag
  };

  assign head        = fifo_mem[rd_ptr];
  assign queue_empty = (count == '0);
  assign bus.in_ready = (count != CNT_FULL);
  assign bus.busy     = !queue_empty || (state != S_IDLE);

  // Exactly one kind, exactly one width, and words must be naturally aligned.
  assign head_legal = (head.is_load ^ head.is_store) &&
                      (head.is_byte ^ head.is_word) &&
                      (!head.is_word || (head.addr[1:0] == 2'b00));

  // A flush empties the queue outright, so nothing is pushed or popped that cycle.
  // A discarded op was already removed by its flush and must not pop a newer entry.
  assign push = bus.in_valid && bus.in_ready && !bus.flush;
  assign pop  = !bus.flush &&
                (((state == S_IDLE) && !queue_empty && !head_legal) ||
                 ((state == S_REQ) && bus.mem_ack && !discard));

  assign rd_byte = bus.mem_rdata[{lane_q, 3'b000} +: 8];

  always_comb begin
    load_result = 32'h0;
    if (load_q) begin
      load_result = byte_q ? {{24{rd_byte[7]}}, rd_byte} : bus.mem_rdata;
    end
  end

  // Queue storage carries no reset; validity is tracked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= in_op;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (!push && pop) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= S_IDLE;
      discard       <= 1'b0;
      lane_q        <= 2'b00;
      byte_q        <= 1'b0;
      load_q        <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= 4'b0000;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
      bus.wb_valid  <= 1'b0;
      bus.wb_tag    <= '0;
      bus.wb_data   <= 32'h0;
      bus.wb_err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          bus.wb_valid <= 1'b0;
          if (!bus.flush && !queue_empty) begin
            bus.wb_tag <= head.tag;
            if (head_legal) begin
              state         <= S_REQ;
              bus.mem_req   <= 1'b1;
              bus.mem_we    <= head.is_store;
              bus.mem_be    <= head.is_byte ? (4'b0001 << head.addr[1:0]) : 4'b1111;
              bus.mem_addr  <= {head.addr[31:2], 2'b00};
              bus.mem_wdata <= head.is_byte ? {4{head.wdata[7:0]}} : head.wdata;
              lane_q        <= head.addr[1:0];
              byte_q        <= head.is_byte;
              load_q        <= head.is_load;
            end else begin
              // Illegal op retires straight away without touching memory.
              state        <= S_WB;
              bus.wb_valid <= 1'b1;
              bus.wb_data  <= 32'h0;
              bus.wb_err   <= 1'b1;
            end
          end
        end

        S_REQ: begin
          // The bus transaction always runs to its ack, even across a flush.
          if (bus.flush) begin
            discard <= 1'b1;
          end
          if (bus.mem_ack) begin
            bus.mem_req <= 1'b0;
            discard     <= 1'b0;
            if (discard || bus.flush) begin
              state <= S_IDLE;
            end else begin
              state        <= S_WB;
              bus.wb_valid <= 1'b1;
              bus.wb_data  <= load_result;
              bus.wb_err   <= 1'b0;
            end
          end
        end

        S_WB: begin
          bus.wb_valid <= 1'b0;
          state        <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_sequencer.sv
module tb_lsu_mem_sequencer;

  localparam int TAG_W = 5;
  localparam int N_RND = 40;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  lsu_mem_sequencer_if #(.TAG_W(TAG_W)) bus ();

  lsu_mem_sequencer #(.DEPTH(4), .TAG_W(TAG_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic             we;
    logic [3:0]       be;
    logic [31:0]      addr;
    logic [31:0]      wdata;
  } mem_rec_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             err;
  } wb_rec_t;

  typedef struct {
    int       req_cycles;
    mem_rec_t req;
    int       wb_cyc;
    wb_rec_t  wb;
  } obs_t;

  int errors = 0;
  int checks = 0;

  wb_rec_t  wb_log[$];
  mem_rec_t mem_log[$];

  // Passive log of completions and accepted memory transactions.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (bus.wb_valid === 1'b1)
        wb_log.push_back('{bus.wb_tag, bus.wb_data, bus.wb_err});
      if (bus.mem_req === 1'b1 && bus.mem_ack === 1'b1)
        mem_log.push_back('{bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata});
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  task automatic push_one(input logic ld, input logic st, input logic by, input logic wd,
                          input logic [31:0] a, input logic [31:0] d, input logic [TAG_W-1:0] t);
    bus.in_is_load  = ld;
    bus.in_is_store = st;
    bus.in_is_byte  = by;
    bus.in_is_word  = wd;
    bus.in_addr     = a;
    bus.in_wdata    = d;
    bus.in_tag      = t;
    bus.in_valid    = 1'b1;
    @(negedge clk);
    bus.in_valid    = 1'b0;
  endtask

  task automatic observe(input int ncyc, output obs_t o);
    o.req_cycles = 0;
    o.req        = '0;
    o.wb_cyc     = -1;
    o.wb         = '0;
    for (int c = 1; c <= ncyc; c++) begin
      if (bus.mem_req === 1'b1) begin
        if (o.req_cycles == 0) o.req = '{bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
        o.req_cycles++;
      end
      if (bus.wb_valid === 1'b1 && o.wb_cyc < 0) begin
        o.wb_cyc = c;
        o.wb     = '{bus.wb_tag, bus.wb_data, bus.wb_err};
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    logic [110:0] outs;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    outs = {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
            bus.wb_valid, bus.wb_tag, bus.wb_data, bus.wb_err, bus.busy};
    checks++;
    if (outs !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h want 0", outs);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_store_word();
    obs_t     o;
    mem_rec_t em;
    wb_rec_t  ew;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0;
    push_one(1'b0, 1'b1, 1'b0, 1'b1, 32'h100, 32'hDEADBEEF, 5'd3);
    observe(6, o);
    em = '{1'b1, 4'b1111, 32'h100, 32'hDEADBEEF};
    ew = '{5'd3, 32'h0, 1'b0};
    checks++;
    if (o.req_cycles !== 1) begin
      errors++;
      $display("FAIL sw_req_cycles: got %0d want 1", o.req_cycles);
    end
    checks++;
    if (o.req !== em) begin
      errors++;
      $display("FAIL sw_req_fields: got %h want %h", o.req, em);
    end
    checks++;
    if (o.wb_cyc !== 3) begin
      errors++;
      $display("FAIL sw_wb_latency: got %0d want 3", o.wb_cyc);
    end
    checks++;
    if (o.wb !== ew) begin
      errors++;
      $display("FAIL sw_wb_fields: got %h want %h", o.wb, ew);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL sw_busy_after: got %b want 0", bus.busy);
    end
  endtask

  task automatic test_load_byte();
    obs_t     o;
    mem_rec_t em;
    wb_rec_t  ew;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h80FF1234;
    push_one(1'b1, 1'b0, 1'b1, 1'b0, 32'h203, 32'h0, 5'd4);
    observe(6, o);
    em = '{1'b0, 4'b1000, 32'h200, 32'h0};
    ew = '{5'd4, 32'hFFFFFF80, 1'b0};
    checks++;
    if (o.req !== em) begin
      errors++;
      $display("FAIL lb3_req_fields: got %h want %h", o.req, em);
    end
    checks++;
    if (o.wb !== ew) begin
      errors++;
      $display("FAIL lb3_wb_fields: got %h want %h", o.wb, ew);
    end
    push_one(1'b1, 1'b0, 1'b1, 1'b0, 32'h201, 32'h0, 5'd5);
    observe(6, o);
    em = '{1'b0, 4'b0010, 32'h200, 32'h0};
    ew = '{5'd5, 32'h00000012, 1'b0};
    checks++;
    if (o.req !== em) begin
      errors++;
      $display("FAIL lb1_req_fields: got %h want %h", o.req, em);
    end
    checks++;
    if (o.wb !== ew) begin
      errors++;
      $display("FAIL lb1_wb_fields: got %h want %h", o.wb, ew);
    end
  endtask

  task automatic test_store_byte();
    obs_t     o;
    mem_rec_t em;
    wb_rec_t  ew;
    bus.mem_ack = 1'b1;
    push_one(1'b0, 1'b1, 1'b1, 1'b0, 32'h12, 32'h000000AB, 5'd6);
    observe(6, o);
    em = '{1'b1, 4'b0100, 32'h10, 32'hABABABAB};
    ew = '{5'd6, 32'h0, 1'b0};
    checks++;
    if (o.req !== em) begin
      errors++;
      $display("FAIL sb_req_fields: got %h want %h", o.req, em);
    end
    checks++;
    if (o.wb !== ew) begin
      errors++;
      $display("FAIL sb_wb_fields: got %h want %h", o.wb, ew);
    end
  endtask

  task automatic test_misaligned();
    wb_rec_t  ew0;
    wb_rec_t  ew1;
    mem_rec_t em;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11223344;
    wb_log.delete();
    mem_log.delete();
    push_one(1'b1, 1'b0, 1'b0, 1'b1, 32'h102, 32'h0, 5'd7);
    push_one(1'b1, 1'b0, 1'b0, 1'b1, 32'h104, 32'h0, 5'd8);
    repeat (8) @(negedge clk);
    ew0 = '{5'd7, 32'h0, 1'b1};
    ew1 = '{5'd8, 32'h11223344, 1'b0};
    em  = '{1'b0, 4'b1111, 32'h104, 32'h0};
    checks++;
    if (wb_log.size() !== 2) begin
      errors++;
      $display("FAIL mis_wb_count: got %0d want 2", wb_log.size());
    end else begin
      checks++;
      if (wb_log[0] !== ew0) begin
        errors++;
        $display("FAIL mis_wb_first: got %h want %h", wb_log[0], ew0);
      end
      checks++;
      if (wb_log[1] !== ew1) begin
        errors++;
        $display("FAIL mis_wb_second: got %h want %h", wb_log[1], ew1);
      end
    end
    checks++;
    if (mem_log.size() !== 1) begin
      errors++;
      $display("FAIL mis_mem_count: got %0d want 1", mem_log.size());
    end else begin
      checks++;
      if (mem_log[0] !== em) begin
        errors++;
        $display("FAIL mis_mem_fields: got %h want %h", mem_log[0], em);
      end
    end
  endtask

  task automatic test_backpressure();
    mem_rec_t em;
    mem_rec_t got;
    wb_rec_t  ew;
    int       g;
    bus.mem_ack = 1'b0;
    wb_log.delete();
    mem_log.delete();
    for (int i = 0; i < 4; i++)
      push_one(1'b0, 1'b1, 1'b0, 1'b1, 32'h400 + 32'(16 * i), 32'hA0000000 + 32'(i), TAG_W'(i));
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_in_ready_full: got %b want 0", bus.in_ready);
    end
    em  = '{1'b1, 4'b1111, 32'h400, 32'hA0000000};
    got = '{bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
    checks++;
    if (bus.mem_req !== 1'b1 || got !== em) begin
      errors++;
      $display("FAIL bp_req_first: got req=%b %h want req=1 %h", bus.mem_req, got, em);
    end
    repeat (3) @(negedge clk);
    got = '{bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
    checks++;
    if (bus.mem_req !== 1'b1 || got !== em) begin
      errors++;
      $display("FAIL bp_req_held: got req=%b %h want req=1 %h", bus.mem_req, got, em);
    end
    bus.mem_ack = 1'b1;
    g = 0;
    while (bus.busy === 1'b1 && g < 40) begin
      @(negedge clk);
      g++;
    end
    checks++;
    if (g >= 40) begin
      errors++;
      $display("FAIL bp_drain_timeout: busy=%b after %0d cycles want 0", bus.busy, g);
    end
    checks++;
    if (wb_log.size() !== 4 || mem_log.size() !== 4) begin
      errors++;
      $display("FAIL bp_counts: got wb=%0d mem=%0d want 4 4", wb_log.size(), mem_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        ew = '{TAG_W'(i), 32'h0, 1'b0};
        checks++;
        if (wb_log[i] !== ew || mem_log[i].addr !== 32'h400 + 32'(16 * i)) begin
          errors++;
          $display("FAIL bp_order_%0d: got wb=%h addr=%h want wb=%h addr=%h",
                   i, wb_log[i], mem_log[i].addr, ew, 32'h400 + 32'(16 * i));
        end
      end
    end
  endtask

  task automatic test_flush_req();
    mem_rec_t em;
    mem_rec_t got;
    bus.mem_ack = 1'b0;
    wb_log.delete();
    mem_log.delete();
    push_one(1'b0, 1'b1, 1'b0, 1'b1, 32'h500, 32'h00000055, 5'd10);
    push_one(1'b1, 1'b0, 1'b0, 1'b1, 32'h504, 32'h0, 5'd11);
    push_one(1'b1, 1'b0, 1'b1, 1'b0, 32'h508, 32'h0, 5'd12);
    // flush with a simultaneous push that must be dropped
    bus.in_is_load  = 1'b1;
    bus.in_is_store = 1'b0;
    bus.in_is_byte  = 1'b0;
    bus.in_is_word  = 1'b1;
    bus.in_addr     = 32'h50C;
    bus.in_tag      = 5'd13;
    bus.in_valid    = 1'b1;
    bus.flush       = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.flush    = 1'b0;
    em  = '{1'b1, 4'b1111, 32'h500, 32'h00000055};
    got = '{bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
    checks++;
    if (bus.mem_req !== 1'b1 || got !== em || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_req_held: got req=%b %h rdy=%b want req=1 %h rdy=1",
               bus.mem_req, got, bus.in_ready, em);
    end
    repeat (2) @(negedge clk);
    bus.mem_ack = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b0;
    checks++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_after_ack: got req=%b busy=%b want 0 0", bus.mem_req, bus.busy);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (wb_log.size() !== 0) begin
      errors++;
      $display("FAIL flush_no_wb: got %0d completions want 0", wb_log.size());
    end
    checks++;
    if (mem_log.size() !== 1 || mem_log[0] !== em) begin
      errors++;
      $display("FAIL flush_store_done: got %0d txns first=%h want 1 %h", mem_log.size(), mem_log[0], em);
    end
  endtask

  task automatic test_reset_mid_req();
    logic [110:0] outs;
    bus.mem_ack = 1'b0;
    push_one(1'b0, 1'b1, 1'b0, 1'b1, 32'h300, 32'h00000077, 5'd21);
    @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstreq_pre: got req=%b want 1", bus.mem_req);
    end
    rst = 1'b1;
    @(negedge clk);
    outs = {bus.mem_req, bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata,
            bus.wb_valid, bus.wb_tag, bus.wb_data, bus.wb_err, bus.busy};
    checks++;
    if (outs !== '0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rstreq_outputs: got %h rdy=%b want 0 rdy=1", outs, bus.in_ready);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.mem_req !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL rstreq_dropped: got req=%b busy=%b want 0 0", bus.mem_req, bus.busy);
    end
  endtask

  task automatic test_random();
    logic             r_ld   [N_RND];
    logic             r_st   [N_RND];
    logic             r_by   [N_RND];
    logic             r_wd   [N_RND];
    logic [31:0]      r_addr [N_RND];
    logic [31:0]      r_wdat [N_RND];
    mem_rec_t         exp_mem[$];
    logic [31:0]      exp_rd [$];
    wb_rec_t          exp_wb [$];
    int               g;

    wb_log.delete();
    bus.mem_ack = 1'b0;
    for (int i = 0; i < N_RND; i++) begin
      int          k;
      int          w;
      int          lane;
      int unsigned b;
      logic [31:0] rd;
      logic [31:0] d;
      logic        legal;
      k = $urandom_range(0, 9);
      w = $urandom_range(0, 9);
      r_ld[i]   = (k < 4) || (k == 8);
      r_st[i]   = (k >= 4 && k < 8) || (k == 8);
      r_by[i]   = (w < 4) || (w == 8);
      r_wd[i]   = (w >= 4 && w < 8) || (w == 8);
      r_addr[i] = $urandom;
      if (r_wd[i] && $urandom_range(0, 4) != 0) r_addr[i] = r_addr[i] - (r_addr[i] % 4);
      r_wdat[i] = $urandom;
      lane  = int'(r_addr[i] % 4);
      legal = (int'(r_ld[i]) + int'(r_st[i]) == 1) && (int'(r_by[i]) + int'(r_wd[i]) == 1) &&
              !(r_wd[i] && lane != 0);
      rd = $urandom;
      if (!legal) begin
        exp_wb.push_back('{TAG_W'(i), 32'h0, 1'b1});
      end else begin
        exp_mem.push_back('{r_st[i],
                            r_by[i] ? 4'(2 ** lane) : 4'hF,
                            r_addr[i] - 32'(lane),
                            r_by[i] ? (r_wdat[i] & 32'hFF) * 32'h01010101 : r_wdat[i]});
        exp_rd.push_back(rd);
        if (r_st[i]) begin
          d = 32'h0;
        end else if (r_wd[i]) begin
          d = rd;
        end else begin
          b = (rd >> (8 * lane)) & 32'hFF;
          d = (b >= 128) ? b + 32'hFFFFFF00 : b;
        end
        exp_wb.push_back('{TAG_W'(i), d, 1'b0});
      end
    end

    fork
      begin
        for (int i = 0; i < N_RND; i++) begin
          int gap;
          int gw;
          gap = $urandom_range(0, 2);
          repeat (gap) @(negedge clk);
          gw = 0;
          while (bus.in_ready !== 1'b1 && gw < 500) begin
            @(negedge clk);
            gw++;
          end
          push_one(r_ld[i], r_st[i], r_by[i], r_wd[i], r_addr[i], r_wdat[i], TAG_W'(i));
        end
      end
      begin
        int       served;
        int       delay;
        int       gr;
        mem_rec_t got;
        served = 0;
        delay  = $urandom_range(0, 3);
        gr     = 0;
        while (served < exp_mem.size() && gr < 3000) begin
          @(negedge clk);
          gr++;
          if (bus.mem_ack === 1'b1) begin
            bus.mem_ack = 1'b0;
          end else if (bus.mem_req === 1'b1) begin
            if (delay > 0) begin
              delay--;
            end else begin
              got = '{bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata};
              checks++;
              if (got !== exp_mem[served]) begin
                errors++;
                $display("FAIL rnd_mem_%0d: got %h want %h", served, got, exp_mem[served]);
              end
              bus.mem_rdata = exp_rd[served];
              bus.mem_ack   = 1'b1;
              served++;
              delay = $urandom_range(0, 3);
            end
          end
        end
        @(negedge clk);
        bus.mem_ack = 1'b0;
        checks++;
        if (served != exp_mem.size()) begin
          errors++;
          $display("FAIL rnd_mem_served: got %0d want %0d", served, exp_mem.size());
        end
      end
    join

    g = 0;
    while (bus.busy === 1'b1 && g < 100) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    checks++;
    if (wb_log.size() != exp_wb.size()) begin
      errors++;
      $display("FAIL rnd_wb_count: got %0d want %0d", wb_log.size(), exp_wb.size());
    end
    for (int i = 0; i < exp_wb.size() && i < wb_log.size(); i++) begin
      checks++;
      if (wb_log[i] !== exp_wb[i]) begin
        errors++;
        $display("FAIL rnd_wb_%0d: got %h want %h", i, wb_log[i], exp_wb[i]);
      end
    end
  endtask

  initial begin
    rst             = 1'b1;
    bus.flush       = 1'b0;
    bus.in_valid    = 1'b0;
    bus.in_is_load  = 1'b0;
    bus.in_is_store = 1'b0;
    bus.in_is_byte  = 1'b0;
    bus.in_is_word  = 1'b0;
    bus.in_addr     = 32'h0;
    bus.in_wdata    = 32'h0;
    bus.in_tag      = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rdata   = 32'h0;
    @(negedge clk);

    test_reset();
    test_store_word();
    test_load_byte();
    test_store_byte();
    test_misaligned();
    test_backpressure();
    test_flush_req();
    test_reset_mid_req();
    test_random();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
